sccb_cfg_sequencer: RTL and testbench
=====================================

Name: sccb_cfg_sequencer

Overview:
- Parametrised camera-register configuration engine; successor to the fixed-width, purely combinational OV7670 configuration table.
- Walks an external combinational config table by index and issues one SCCB/I2C register write per entry through a byte-level I2C master.
- Adds a power-up wait, in-table delay entries, a configurable table length, NACK retry, re-trigger and error reporting.
- Sits between the camera config table and the I2C master in the OV7670/SDRAM/VGA path; cfg_done gates the capture logic.

Parameters:
- REG_ADDR_W, 8: register address width (8 for OV7670, 16 for 16-bit-address sensors).
- DATA_W, 8: register data width.
- LUT_SIZE, 165: number of valid table entries, indices 0..LUT_SIZE-1.
- IDX_W, 8: width of lut_index; LUT_SIZE <= 2**IDX_W.
- CLK_PER_MS, 25000: clk cycles per millisecond.
- POWERUP_MS, 2: wait after reset or start before the first write.
- DELAY_ADDR, all-ones of REG_ADDR_W: address value marking a delay entry.
- MAX_RETRY, 3: extra attempts after a NACK.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; restarts the full sequence when idle, done or in error
- lut_index  out  IDX_W  table index
- lut_data  in  REG_ADDR_W+DATA_W  table word: {reg_addr, reg_data}
- i2c_req  out  1  write request to the I2C master; held until i2c_ack or i2c_nack
- i2c_addr  out  REG_ADDR_W  register address
- i2c_wdata  out  DATA_W  register data
- i2c_ack  in  1  one-cycle pulse: write completed and acknowledged
- i2c_nack  in  1  one-cycle pulse: write completed, slave NACK
- busy  out  1  sequence in progress
- cfg_done  out  1  all entries written; sticky until start or rst
- cfg_err  out  1  retries exhausted; sticky until start or rst
- err_index  out  IDX_W  index of the failing entry

Behaviour:
- Reset values: lut_index=0, i2c_req=0, i2c_addr=0, i2c_wdata=0, busy=0, cfg_done=0, cfg_err=0, err_index=0. After reset release, state=PWRUP; no start pulse is needed.
- States: IDLE, PWRUP, FETCH, ISSUE, WAIT, DELAY, NEXT, DONE, ERR.
- busy=1 in PWRUP, FETCH, ISSUE, WAIT, DELAY and NEXT.
- IDLE: entered only via DONE or ERR. start -> PWRUP, lut_index=0, retry count=0, cfg_done=0, cfg_err=0.
- PWRUP: count POWERUP_MS*CLK_PER_MS cycles, then -> FETCH. The cycle counter is wide enough for 255*CLK_PER_MS.
- FETCH: one cycle; register lut_data, which is valid one cycle after lut_index changes.
  - Latched address == DELAY_ADDR -> DELAY, loading data*CLK_PER_MS.
  - Otherwise -> ISSUE.
- ISSUE: drive i2c_addr/i2c_wdata from the latch and assert i2c_req; -> WAIT.
- WAIT: hold i2c_req, i2c_addr and i2c_wdata stable.
  - i2c_ack: drop i2c_req -> NEXT.
  - i2c_nack with retries < MAX_RETRY: drop i2c_req, increment retry -> ISSUE, so i2c_req is low for at least one cycle.
  - i2c_nack with retries == MAX_RETRY: err_index=lut_index, cfg_err=1 -> ERR.
  - If both pulses arrive in the same cycle, nack takes priority.
- DELAY: count down to 0 -> NEXT. A data value of 0 gives a 1-cycle pass-through.
- NEXT: clear the retry count.
  - lut_index == LUT_SIZE-1 -> DONE.
  - Otherwise lut_index+1 -> FETCH.
  - lut_index never wraps.
- DONE: cfg_done=1, -> IDLE.
- ERR: -> IDLE with cfg_err held.
- Latency per normal entry: FETCH(1) + ISSUE(1) + I2C time + NEXT(1).
- start while busy: ignored.
- start in the same cycle as entering DONE: ignored; the start pulse must arrive in IDLE.
- rst mid-transaction: i2c_req drops immediately; the I2C master is reset by the same rst.
- i2c_ack or i2c_nack outside WAIT: ignored.
- A soft-reset entry (e.g. 0x12 <- 0x80) must be followed in the table by a delay entry; the block does not special-case any register.

Decomposition:
- Shared package sccb_cfg_pkg holds:
  - state encoding enum;
  - default DELAY_ADDR per address width;
  - ms_to_cycles helper constant.
- Sub-module ms_timer (load value, count, expired pulse) is shared by PWRUP and DELAY.
- Table modules stay combinational and separate; this block only indexes them.

Test Plan:
- Setup: CLK_PER_MS=4, POWERUP_MS=2, LUT_SIZE=3, model table {0x3a04, 0xFF05, 0x1214}, master acks 5 cycles after req.
- Power-up and delay entry: release rst -> no i2c_req for 8 cycles; writes 0x3a/0x04, then a 20-cycle gap with no req, then 0x12/0x14; cfg_done=1, busy=0, lut_index=2.
- NACK retry: master NACKs entry 0 twice then acks -> three req pulses with identical addr/data, i2c_req low at least 1 cycle between them, sequence completes, cfg_err=0.
- Retry exhaustion: master always NACKs entry 2 -> exactly 4 attempts; cfg_err=1, err_index=2, cfg_done=0, busy=0.
- Restart after error: start pulse after the error case -> cfg_err clears, PWRUP 8 cycles, index 0 rewritten, completes with cfg_done=1.
- Reset mid-WAIT: assert rst while i2c_req=1 -> i2c_req=0 in the same cycle, all outputs at reset values, clean restart after release.
- Ignored start and stray ack: start pulse during WAIT and i2c_ack during DELAY -> no effect on state, index or outputs.

Source files
------------

// File: rtl/sccb_cfg_pkg.sv
// Shared types and helpers for the camera register configuration sequencer.
package sccb_cfg_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_PWRUP,
        S_FETCH,
        S_ISSUE,
        S_WAIT,
        S_DELAY,
        S_NEXT,
        S_DONE,
        S_ERR
    } state_t;

    // A table address of all ones marks a delay entry rather than a register write.
    function automatic logic [31:0] dflt_delay_addr(input int unsigned addr_w);
        if (addr_w >= 32)
            return '1;
        return (32'h1 << addr_w) - 32'h1;
    endfunction

    function automatic int unsigned ms_to_cycles(input int unsigned ms, input int unsigned clk_per_ms);
        return ms * clk_per_ms;
    endfunction

endpackage

// File: rtl/ms_timer.sv
// Loadable down-counter; o_expired is held high while the count sits at zero.
module ms_timer #(
    parameter int               CNT_W   = 16,
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_expired
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_cnt <= RST_VAL;
        else if (i_load)
            r_cnt <= i_load_val;
        else if (r_cnt != '0)
            r_cnt <= r_cnt - 1'b1;
    end

    assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/sccb_cfg_sequencer.sv
// Walks a combinational register table and issues one SCCB write per entry,
// with power-up wait, in-table delays, NACK retry and sticky done/error flags.
module sccb_cfg_sequencer
    import sccb_cfg_pkg::*;
#(
    parameter int                    REG_ADDR_W = 8,
    parameter int                    DATA_W     = 8,
    parameter int                    LUT_SIZE   = 165,
    parameter int                    IDX_W      = 8,
    parameter int                    CLK_PER_MS = 25000,
    parameter int                    POWERUP_MS = 2,
    parameter logic [REG_ADDR_W-1:0] DELAY_ADDR = REG_ADDR_W'(dflt_delay_addr(REG_ADDR_W)),
    parameter int                    MAX_RETRY  = 3
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_start,
    output logic [IDX_W-1:0]             o_lut_index,
    input  logic [REG_ADDR_W+DATA_W-1:0] i_lut_data,
    output logic                         o_i2c_req,
    output logic [REG_ADDR_W-1:0]        o_i2c_addr,
    output logic [DATA_W-1:0]            o_i2c_wdata,
    input  logic                         i_i2c_ack,
    input  logic                         i_i2c_nack,
    output logic                         o_busy,
    output logic                         o_cfg_done,
    output logic                         o_cfg_err,
    output logic [IDX_W-1:0]             o_err_index
);

    localparam int PWR_CYC = int'(ms_to_cycles(POWERUP_MS, CLK_PER_MS));
    localparam int MAX_MS  = (POWERUP_MS > 255) ? POWERUP_MS : 255;
    localparam int CNT_W   = $clog2(int'(ms_to_cycles(MAX_MS, CLK_PER_MS)) + 1);
    localparam int RTY_W   = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    // Loaded with N-1 so the timed state lasts exactly N cycles.
    localparam logic [CNT_W-1:0] PWR_LOAD = (PWR_CYC == 0) ? '0 : CNT_W'(PWR_CYC - 1);

    state_t                r_state;
    logic [REG_ADDR_W-1:0] r_addr_lat;
    logic [DATA_W-1:0]     r_data_lat;
    logic [RTY_W-1:0]      r_retry;
    logic                  w_tmr_load;
    logic                  w_tmr_exp;
    logic [CNT_W-1:0]      w_tmr_val;
    logic [REG_ADDR_W-1:0] w_lut_addr;
    logic [DATA_W-1:0]     w_lut_data;

    assign w_lut_addr = i_lut_data[REG_ADDR_W+DATA_W-1 -: REG_ADDR_W];
    assign w_lut_data = i_lut_data[DATA_W-1:0];

    // FETCH always reloads the timer; the value only matters when the entry is a delay.
    assign w_tmr_load = (r_state == S_FETCH) || ((r_state == S_IDLE) && i_start);
    assign w_tmr_val  = (r_state == S_FETCH) ? CNT_W'(w_lut_data) * CNT_W'(CLK_PER_MS) : PWR_LOAD;

    ms_timer #(
        .CNT_W   (CNT_W),
        .RST_VAL (PWR_LOAD)
    ) u_timer (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_expired  (w_tmr_exp)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_PWRUP;
            r_addr_lat  <= '0;
            r_data_lat  <= '0;
            r_retry     <= '0;
            o_lut_index <= '0;
            o_i2c_req   <= 1'b0;
            o_i2c_addr  <= '0;
            o_i2c_wdata <= '0;
            o_busy      <= 1'b0;
            o_cfg_done  <= 1'b0;
            o_cfg_err   <= 1'b0;
            o_err_index <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state     <= S_PWRUP;
                        o_lut_index <= '0;
                        r_retry     <= '0;
                        o_cfg_done  <= 1'b0;
                        o_cfg_err   <= 1'b0;
                        o_busy      <= 1'b1;
                    end
                end
                S_PWRUP: begin
                    o_busy <= 1'b1;
                    if (w_tmr_exp)
                        r_state <= S_FETCH;
                end
                S_FETCH: begin
                    r_addr_lat <= w_lut_addr;
                    r_data_lat <= w_lut_data;
                    r_state    <= (w_lut_addr == DELAY_ADDR) ? S_DELAY : S_ISSUE;
                end
                S_ISSUE: begin
                    o_i2c_req   <= 1'b1;
                    o_i2c_addr  <= r_addr_lat;
                    o_i2c_wdata <= r_data_lat;
                    r_state     <= S_WAIT;
                end
                S_WAIT: begin
                    if (i_i2c_nack) begin
                        o_i2c_req <= 1'b0;
                        if (r_retry == RTY_W'(MAX_RETRY)) begin
                            o_err_index <= o_lut_index;
                            o_cfg_err   <= 1'b1;
                            o_busy      <= 1'b0;
                            r_state     <= S_ERR;
                        end else begin
                            r_retry <= r_retry + 1'b1;
                            r_state <= S_ISSUE;
                        end
                    end else if (i_i2c_ack) begin
                        o_i2c_req <= 1'b0;
                        r_state   <= S_NEXT;
                    end
                end
                S_DELAY: begin
                    if (w_tmr_exp)
                        r_state <= S_NEXT;
                end
                S_NEXT: begin
                    r_retry <= '0;
                    if (o_lut_index == IDX_W'(LUT_SIZE - 1)) begin
                        o_busy  <= 1'b0;
                        r_state <= S_DONE;
                    end else begin
                        o_lut_index <= o_lut_index + 1'b1;
                        r_state     <= S_FETCH;
                    end
                end
                S_DONE: begin
                    o_cfg_done <= 1'b1;
                    r_state    <= S_IDLE;
                end
                S_ERR: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sccb_cfg_sequencer.sv
// Bench for sccb_cfg_sequencer: a table-driven model predicts every write attempt
// (index, addr, data, idle gap before it) and a compare process checks each cycle.
module tb_sccb_cfg_sequencer;

    localparam int AW = 8, DW = 8, LUT_SIZE = 3, IW = 8, CPM = 4, PUMS = 2, MAXR = 3;

    logic          clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [IW-1:0] lut_index, err_index;
    logic [15:0]   lut_data;
    logic          req, busy, done, err, ack;
    logic [AW-1:0] i2c_addr;
    logic [DW-1:0] i2c_wdata;
    logic          m_ack = 1'b0, m_nack = 1'b0, stray_ack = 1'b0;

    logic [15:0] table_mem [4] = '{16'h3a04, 16'hFF05, 16'h1214, 16'h0000};

    assign lut_data = (lut_index < 8'(LUT_SIZE)) ? table_mem[lut_index[1:0]] : 16'h0000;
    assign ack      = m_ack | stray_ack;

    always #5 clk = ~clk;

    sccb_cfg_sequencer #(
        .REG_ADDR_W (AW), .DATA_W (DW), .LUT_SIZE (LUT_SIZE), .IDX_W (IW),
        .CLK_PER_MS (CPM), .POWERUP_MS (PUMS), .DELAY_ADDR (8'hFF), .MAX_RETRY (MAXR)
    ) dut (
        .i_clk (clk), .i_rst (rst), .i_start (start),
        .o_lut_index (lut_index), .i_lut_data (lut_data),
        .o_i2c_req (req), .o_i2c_addr (i2c_addr), .o_i2c_wdata (i2c_wdata),
        .i_i2c_ack (ack), .i_i2c_nack (m_nack),
        .o_busy (busy), .o_cfg_done (done), .o_cfg_err (err), .o_err_index (err_index)
    );

    typedef struct { int idx; logic [7:0] a; logic [7:0] d; int gap; } att_t;

    att_t exp_q[$];
    int   nack_cfg [LUT_SIZE];
    int   att_cnt  [LUT_SIZE];
    int   checks = 0, errors = 0;
    int   rises = 0;
    logic exp_done, exp_err;
    int   exp_err_idx;

    task automatic chk(input string name, input longint act, input longint expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // Expected attempts from the table and the master's NACK plan. Gap = idle cycles
    // before the request: PWRUP+FETCH+ISSUE first, NEXT+FETCH+ISSUE after an ack,
    // one ISSUE cycle after a NACK, and each delay entry adds DELAY(d*CPM+1)+NEXT+FETCH.
    task automatic plan_run();
        int pend, n;
        logic [7:0] a, d;
        exp_q.delete();
        pend = PUMS * CPM + 2;
        exp_done = 1'b1; exp_err = 1'b0; exp_err_idx = 0;
        rises = 0;
        for (int i = 0; i < LUT_SIZE; i++) begin
            att_cnt[i] = 0;
        end
        for (int i = 0; i < LUT_SIZE; i++) begin
            if (exp_err) break;
            a = table_mem[2'(i)][15:8];
            d = table_mem[2'(i)][7:0];
            if (a == 8'hFF) begin
                pend += int'(d) * CPM + 3;
            end else begin
                n = (nack_cfg[i] > MAXR) ? MAXR + 1 : nack_cfg[i] + 1;
                for (int k = 0; k < n; k++)
                    exp_q.push_back('{i, a, d, (k == 0) ? pend : 1});
                if (nack_cfg[i] > MAXR) begin
                    exp_done = 1'b0; exp_err = 1'b1; exp_err_idx = i;
                end
                pend = 3;
            end
        end
    endtask

    // Compare process: every request rise must match the head of the model queue.
    initial begin
        int   low_cnt;
        logic prev_req, have_cur;
        att_t cur;
        low_cnt = 0; prev_req = 1'b0; have_cur = 1'b0;
        cur = '{0, 8'h00, 8'h00, 0};
        forever begin
            @(negedge clk);
            if (rst) begin
                low_cnt = 0; prev_req = 1'b0; have_cur = 1'b0;
                continue;
            end
            if (busy) begin
                chk("busy_vs_done", done, 0);
                chk("busy_vs_err", err, 0);
            end
            if (start && !busy)
                low_cnt = 0;
            else if (!req)
                low_cnt++;
            if (req && !prev_req) begin
                rises++;
                if (exp_q.size() == 0) begin
                    checks++; errors++; have_cur = 1'b0;
                    $display("FAIL unexpected_req: idx %0d addr %0h", lut_index, i2c_addr);
                end else begin
                    cur = exp_q.pop_front();
                    have_cur = 1'b1;
                    chk("req_gap", low_cnt, cur.gap);
                    chk("req_idx", lut_index, cur.idx);
                end
            end
            if (req) begin
                low_cnt = 0;
                if (have_cur) begin
                    chk("req_addr", i2c_addr, cur.a);
                    chk("req_data", i2c_wdata, cur.d);
                end
                chk("req_busy", busy, 1);
            end
            prev_req = req;
        end
    end

    // I2C master: answers each request 5 cycles later, NACKing per nack_cfg.
    initial begin
        int wc, ix;
        logic act;
        act = 1'b0; wc = 0;
        forever begin
            @(negedge clk);
            m_ack = 1'b0; m_nack = 1'b0;
            if (rst) begin
                act = 1'b0;
            end else if (act) begin
                wc++;
                if (wc == 5) begin
                    act = 1'b0;
                    ix = int'(lut_index);
                    if (att_cnt[ix] < nack_cfg[ix]) m_nack = 1'b1;
                    else                            m_ack  = 1'b1;
                    att_cnt[ix]++;
                end
            end else if (req) begin
                act = 1'b1; wc = 0;
            end
        end
    end

    task automatic do_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_end(input string name);
        int n;
        n = 0;
        while (!(done || err) && n < 400) begin
            @(negedge clk); n++;
        end
        if (n >= 400) begin
            checks++; errors++;
            $display("FAIL %s_timeout: no done/err after %0d cycles", name, n);
        end
        repeat (3) @(negedge clk);
        chk({name, "_done"}, done, exp_done);
        chk({name, "_err"}, err, exp_err);
        chk({name, "_busy"}, busy, 0);
        chk({name, "_q_left"}, exp_q.size(), 0);
    endtask

    task automatic wait_req(input logic lvl, input string name);
        int n;
        n = 0;
        while (req !== lvl && n < 200) begin
            @(negedge clk); n++;
        end
        if (n >= 200) begin
            checks++; errors++;
            $display("FAIL %s_timeout: req stuck at %0d", name, req);
        end
    endtask

    initial begin
        for (int i = 0; i < LUT_SIZE; i++) nack_cfg[i] = 0;

        // Power-up, write, delay entry, write
        plan_run();
        chk("model_attempts", exp_q.size(), 2);
        chk("model_pwrup_gap", exp_q[0].gap, 10);
        chk("model_delay_gap", exp_q[1].gap, 26);
        repeat (2) @(negedge clk);
        chk("rst_req", req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_index", lut_index, 0);
        @(posedge clk); #1 rst = 1'b0;
        wait_end("basic");
        chk("basic_index", lut_index, 2);
        chk("basic_rises", rises, 2);

        // Two NACKs on entry 0, then ack
        nack_cfg[0] = 2;
        plan_run();
        chk("model_retry_attempts", exp_q.size(), 4);
        chk("model_retry_gap", exp_q[1].gap, 1);
        do_start();
        @(negedge clk);
        chk("start_clears_done", done, 0);
        wait_end("retry");
        chk("retry_rises", rises, 4);

        // Entry 2 always NACKs
        nack_cfg[0] = 0; nack_cfg[2] = 99;
        plan_run();
        chk("model_exhaust_attempts", exp_q.size(), 5);
        do_start();
        wait_end("exhaust");
        chk("exhaust_err_index", err_index, 2);
        chk("exhaust_rises", rises, 5);

        // Restart after error
        nack_cfg[2] = 0;
        plan_run();
        do_start();
        @(negedge clk);
        chk("restart_err_clear", err, 0);
        wait_end("restart");
        chk("restart_rises", rises, 2);

        // Reset while a write is outstanding
        plan_run();
        do_start();
        wait_req(1'b1, "rstmid");
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rstmid_req", req, 0);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_done", done, 0);
        chk("rstmid_err", err, 0);
        chk("rstmid_index", lut_index, 0);
        chk("rstmid_addr", i2c_addr, 0);
        chk("rstmid_wdata", i2c_wdata, 0);
        chk("rstmid_err_index", err_index, 0);
        plan_run();
        @(posedge clk); #1 rst = 1'b0;
        wait_end("rstmid");
        chk("rstmid_rises", rises, 2);

        // Start while busy and a stray ack during the delay are both ignored
        plan_run();
        do_start();
        wait_req(1'b1, "stray_req");
        do_start();
        wait_req(1'b0, "stray_fall");
        repeat (8) @(negedge clk);
        stray_ack = 1'b1;
        @(negedge clk);
        stray_ack = 1'b0;
        wait_end("stray");
        chk("stray_index", lut_index, 2);
        chk("stray_rises", rises, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
